// File: rtl/resizer_pkg.sv
// resizer_pkg: shared lane type, popcount and count-width helpers for the resizer/packer stages
package resizer_pkg;

    localparam int T_DATA_WIDTH_DEF = 4;

    typedef logic [T_DATA_WIDTH_DEF-1:0] lane_t;

    // Bits needed to hold a count in 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/lane_compact.sv
// lane_compact: packs the kept lanes of one beat into contiguous low lanes
//   keep_i : per-lane valid mask
//   data_i : lane data
//   data_o : kept lanes in ascending order from lane 0, unused lanes zero
//   cnt_o  : number of kept lanes
module lane_compact
    import resizer_pkg::*;
#(
    parameter int KEEP_WIDTH   = 2,
    parameter int T_DATA_WIDTH = 4
) (
    input  logic [KEEP_WIDTH-1:0]            keep_i,
    input  logic [T_DATA_WIDTH-1:0]          data_i [KEEP_WIDTH],
    output logic [T_DATA_WIDTH-1:0]          data_o [KEEP_WIDTH],
    output logic [count_width(KEEP_WIDTH)-1:0] cnt_o
);

    localparam int KW = count_width(KEEP_WIDTH);

    // pos is the running prefix sum of keep bits: the destination slot of lane i.
    always_comb begin
        int pos;
        pos = 0;
        data_o = '{default: '0};
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            for (int j = 0; j < KEEP_WIDTH; j++)
                if (keep_i[i] && j == pos) data_o[j] = data_i[i];
            pos += int'(keep_i[i]);
        end
        cnt_o = KW'(popcount(32'(keep_i)));
    end

endmodule

// File: rtl/stream_packer.sv
// stream_packer: re-packs sparse-keep beats into fully populated beats, preserving packet boundaries
//   clk, rst                        : clock, asynchronous active-high reset
//   s_valid_i/s_ready_o/s_last_i    : input handshake and end of packet
//   s_keep_i/s_data_i               : input lane mask (any pattern) and lane data
//   m_valid_o/m_ready_i/m_last_o    : output handshake and end of packet
//   m_keep_o/m_data_o               : contiguous low-lane mask and packed lane data
module stream_packer
    import resizer_pkg::*;
#(
    parameter int KEEP_WIDTH   = 2,
    parameter int T_DATA_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic                    s_last_i,
    input  logic [KEEP_WIDTH-1:0]   s_keep_i,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [KEEP_WIDTH],
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    m_last_o,
    output logic [KEEP_WIDTH-1:0]   m_keep_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [KEEP_WIDTH]
);

    localparam int BUF_DEPTH = 2 * KEEP_WIDTH;
    localparam int CW        = count_width(BUF_DEPTH);
    localparam int KW        = count_width(KEEP_WIDTH);

    logic [T_DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [T_DATA_WIDTH-1:0] buf_d [BUF_DEPTH];
    logic [T_DATA_WIDTH-1:0] cp_data [KEEP_WIDTH];
    logic [KW-1:0]           cp_cnt;
    logic [CW-1:0]           cnt_q, cnt_d, n, base;
    logic                    last_q, last_d, push, pop;

    lane_compact #(
        .KEEP_WIDTH  (KEEP_WIDTH),
        .T_DATA_WIDTH(T_DATA_WIDTH)
    ) u_compact (
        .keep_i(s_keep_i),
        .data_i(s_data_i),
        .data_o(cp_data),
        .cnt_o (cp_cnt)
    );

    // Ready depends only on state, so there is no path from m_ready_i.
    assign s_ready_o = !rst && !last_q && cnt_q <= CW'(KEEP_WIDTH);
    assign m_valid_o = cnt_q >= CW'(KEEP_WIDTH) || last_q;
    assign m_last_o  = last_q && cnt_q <= CW'(KEEP_WIDTH);
    assign n         = cnt_q < CW'(KEEP_WIDTH) ? cnt_q : CW'(KEEP_WIDTH);
    assign push      = s_valid_i && s_ready_o;
    assign pop       = m_valid_o && m_ready_i;
    // base is where the new lanes land, after any pop has shifted the buffer.
    assign base      = pop ? cnt_q - n : cnt_q;
    assign cnt_d     = base + (push ? CW'(cp_cnt) : '0);
    assign last_d    = push && s_last_i ? 1'b1 : pop && m_last_o ? 1'b0 : last_q;

    always_comb begin
        m_keep_o = '0;
        m_data_o = '{default: '0};
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            m_keep_o[i] = CW'(i) < n;
            m_data_o[i] = CW'(i) < n ? buf_q[i] : '0;
        end
    end

    // Entries above the fill level are kept at zero.
    always_comb begin
        buf_d = '{default: '0};
        for (int i = 0; i < BUF_DEPTH; i++) begin
            for (int j = 0; j < BUF_DEPTH; j++)
                if (j < int'(cnt_q) && j == i + (pop ? int'(n) : 0)) buf_d[i] = buf_q[j];
            for (int j = 0; j < KEEP_WIDTH; j++)
                if (push && j < int'(cp_cnt) && i == int'(base) + j) buf_d[i] = cp_data[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
            buf_q  <= '{default: '0};
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            buf_q  <= buf_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) cnt_q <= CW'(BUF_DEPTH));

endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: randomized and directed checks of stream_packer against a lane-queue model
module tb_stream_packer;

    localparam int K = 2;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid_i, s_ready_o, s_last_i;
    logic [K-1:0] s_keep_i;
    logic [T-1:0] s_data_i [K];
    logic         m_valid_o, m_ready_i, m_last_o;
    logic [K-1:0] m_keep_o;
    logic [T-1:0] m_data_o [K];

    int           checks = 0;
    int           failures = 0;
    logic [T-1:0] mq[$];
    logic         mpend;

    stream_packer #(.KEEP_WIDTH(K), .T_DATA_WIDTH(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .s_last_i (s_last_i),
        .s_keep_i (s_keep_i),
        .s_data_i (s_data_i),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .m_last_o (m_last_o),
        .m_keep_o (m_keep_o),
        .m_data_o (m_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [K*T-1:0] dut_data();
        logic [K*T-1:0] v;
        for (int i = 0; i < K; i++) v[i*T +: T] = m_data_o[i];
        return v;
    endfunction

    task automatic idle_chk(input string tag);
        check({tag, ".valid"}, m_valid_o, 0);
        check({tag, ".last"}, m_last_o, 0);
        check({tag, ".keep"}, m_keep_o, 0);
        check({tag, ".data"}, dut_data(), 0);
        check({tag, ".ready"}, s_ready_o, 0);
    endtask

    // Called just after a falling edge: drive, compare against the model, advance the model.
    task automatic step(input string tag, input logic v, input logic [K-1:0] k, input logic l,
                        input logic [K*T-1:0] dv, input logic mr);
        int n;
        logic er, ev, el;
        logic [K-1:0] ek;
        logic [K*T-1:0] ed;
        s_valid_i = v;
        s_keep_i  = k;
        s_last_i  = l;
        m_ready_i = mr;
        for (int i = 0; i < K; i++) s_data_i[i] = dv[i*T +: T];
        #1;
        n  = mq.size() < K ? mq.size() : K;
        er = !mpend && mq.size() <= K;
        ev = mq.size() >= K || mpend;
        el = mpend && mq.size() <= K;
        ek = '0;
        ed = '0;
        for (int i = 0; i < n; i++) begin
            ed[i*T +: T] = mq[i];
            ek[i] = 1'b1;
        end
        check({tag, ".ready"}, s_ready_o, er);
        check({tag, ".valid"}, m_valid_o, ev);
        if (ev) begin
            check({tag, ".last"}, m_last_o, el);
            check({tag, ".keep"}, m_keep_o, ek);
            check({tag, ".data"}, dut_data(), ed);
        end
        if (ev && mr) begin
            repeat (n) void'(mq.pop_front());
            if (el) mpend = 1'b0;
        end
        if (v && er) begin
            for (int i = 0; i < K; i++) if (k[i]) mq.push_back(dv[i*T +: T]);
            if (l) mpend = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 20 && (mq.size() > 0 || mpend); c++) step(tag, 0, '0, 0, '0, 1);
        step({tag, ".idle"}, 0, '0, 0, '0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        s_valid_i = 0;
        s_last_i = 0;
        s_keep_i = '0;
        m_ready_i = 0;
        s_data_i = '{default: '0};
        mpend = 1'b0;
        @(negedge clk);
        #1 idle_chk("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        step("dense", 1, 2'b11, 0, 8'h21, 1);
        step("dense", 1, 2'b11, 1, 8'h43, 1);
        drain("dense");

        step("sparse", 1, 2'b01, 0, 8'hA5, 1);
        step("sparse", 1, 2'b10, 0, 8'h6B, 1);
        step("sparse", 1, 2'b11, 1, 8'h87, 1);
        drain("sparse");

        step("tail", 1, 2'b11, 0, 8'h21, 1);
        step("tail", 1, 2'b01, 1, 8'hF3, 1);
        step("tail_stall", 1, 2'b11, 0, 8'hEE, 1);
        drain("tail");

        step("zlp", 1, 2'b00, 1, 8'h00, 1);
        drain("zlp");
        step("empty", 1, 2'b00, 0, 8'h55, 1);
        drain("empty");

        for (int i = 0; i < 5; i++) step("bp", 1, 2'b11, 0, K*T'($urandom), 0);
        drain("bp");

        for (int i = 0; i < 800; i++)
            step("rand", $urandom_range(0, 3) != 0, K'($urandom), $urandom_range(0, 4) == 0,
                 K*T'($urandom), $urandom_range(0, 3) != 0);
        drain("rand");

        step("rst_mid", 1, 2'b11, 0, 8'h21, 0);
        step("rst_mid", 1, 2'b01, 0, 8'h03, 0);
        step("rst_mid", 0, 2'b00, 0, 8'h00, 0);
        rst = 1'b1;
        #1 idle_chk("rst_mid.async");
        mq.delete();
        mpend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        step("post_rst", 1, 2'b11, 1, 8'hA9, 1);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
